// File: rtl/alarm_ring_controller.sv
// alarm_ring_controller
//   Runs one alarm ringing session, started by a rising edge of match.
//   In RINGING the buzzer follows a 1 Hz on/off pattern. A snooze pauses
//   ringing for SNOOZE_SEC seconds, up to MAX_SNOOZES times per session.
//   A stop ends the session. Ringing for RING_TIMEOUT_SEC seconds without
//   an answer ends the session and sets the sticky missed flag.
//
//   Ports:
//     clk, reset    system clock, synchronous active-high reset
//     enable        alarm armed; low forces IDLE
//     tick_1hz      one-clk pulse per second
//     match         alarm compare level; its rising edge starts a session
//     snooze_btn    debounced level; its rising edge requests a snooze
//     stop_btn      debounced level; its rising edge ends the session
//     buzzer        buzzer drive
//     ringing       high in RINGING
//     snoozed       high in SNOOZED
//     snooze_count  snoozes used in the current session
//     remaining_sec seconds left in SNOOZED, 0 otherwise
//     missed        last session ended by timeout (sticky)
//
//   Optional feature macro ALARM_ESCALATE_EN: when defined, the buzzer is
//   held on continuously once half of the ring timeout has elapsed.
module alarm_ring_controller #(
  parameter int SNOOZE_SEC       = 300,
  parameter int RING_TIMEOUT_SEC = 60,
  parameter int MAX_SNOOZES      = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  input  logic       tick_1hz,
  input  logic       match,
  input  logic       snooze_btn,
  input  logic       stop_btn,
  output logic       buzzer,
  output logic       ringing,
  output logic       snoozed,
  output logic [2:0] snooze_count,
  output logic [9:0] remaining_sec,
  output logic       missed
);

  localparam logic [9:0] SNOOZE_LIM = 10'(SNOOZE_SEC);
  localparam logic [9:0] RING_LIM   = 10'(RING_TIMEOUT_SEC);
  localparam logic [9:0] ESC_LIM    = 10'(RING_TIMEOUT_SEC / 2);
  localparam logic [2:0] SNZ_MAX    = 3'(MAX_SNOOZES);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RINGING = 2'd1,
    SNOOZED = 2'd2
  } state_t;

  state_t     state, state_n;
  logic [9:0] sec_cnt, sec_n;
  logic       phase, phase_n;
  logic [2:0] count_n;
  logic       missed_n;

  // Input history and registered rising-edge pulses
  logic match_p0, snooze_p0, stop_p0;
  logic match_rise_p1, snooze_rise_p1, stop_rise_p1;

  // Buzzer drive for the state being entered
  function automatic logic buzz_drive(input state_t s, input logic [9:0] sec,
                                      input logic ph);
    logic b;
    b = 1'b0;
    if (s == RINGING) begin
`ifdef ALARM_ESCALATE_EN
      b = (sec >= ESC_LIM) ? 1'b1 : ph;
`else
      b = ph;
`endif
    end
    return b;
  endfunction

  function automatic logic [9:0] remain(input state_t s, input logic [9:0] sec);
    return (s == SNOOZED) ? (SNOOZE_LIM - sec) : 10'd0;
  endfunction

  // Stage p1 -> state: next-state decision from the registered edge pulses.
  // Edge priority is stop > snooze > tick, so a tick that coincides with a
  // state-changing button edge is dropped.
  always_comb begin
    state_n  = state;
    sec_n    = sec_cnt;
    phase_n  = phase;
    count_n  = snooze_count;
    missed_n = missed;
    if (!enable) begin
      state_n = IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (match_rise_p1) begin
            state_n  = RINGING;
            sec_n    = 10'd0;
            phase_n  = 1'b1;
            count_n  = 3'd0;
            missed_n = 1'b0;
          end
        end
        RINGING: begin
          if (stop_rise_p1) begin
            state_n  = IDLE;
            missed_n = 1'b0;
          end else if (snooze_rise_p1 && (snooze_count < SNZ_MAX)) begin
            state_n = SNOOZED;
            sec_n   = 10'd0;
            count_n = snooze_count + 3'd1;
          end else if (tick_1hz) begin
            sec_n   = sec_cnt + 10'd1;
            phase_n = ~phase;
            if (sec_n == RING_LIM) begin
              state_n  = IDLE;
              missed_n = 1'b1;
            end
          end
        end
        SNOOZED: begin
          if (stop_rise_p1) begin
            state_n = IDLE;
          end else if (tick_1hz) begin
            sec_n = sec_cnt + 10'd1;
            if (sec_n == SNOOZE_LIM) begin
              state_n = RINGING;
              sec_n   = 10'd0;
              phase_n = 1'b1;
            end
          end
        end
        default: state_n = IDLE;
      endcase
    end
  end

  // Stage p0 -> p1: edge detect; state and all outputs registered together
  always_ff @(posedge clk) begin
    if (reset) begin
      match_p0       <= 1'b0;
      snooze_p0      <= 1'b0;
      stop_p0        <= 1'b0;
      match_rise_p1  <= 1'b0;
      snooze_rise_p1 <= 1'b0;
      stop_rise_p1   <= 1'b0;
      state          <= IDLE;
      sec_cnt        <= 10'd0;
      phase          <= 1'b0;
      snooze_count   <= 3'd0;
      missed         <= 1'b0;
      buzzer         <= 1'b0;
      ringing        <= 1'b0;
      snoozed        <= 1'b0;
      remaining_sec  <= 10'd0;
    end else begin
      match_p0       <= match;
      snooze_p0      <= snooze_btn;
      stop_p0        <= stop_btn;
      match_rise_p1  <= match & ~match_p0;
      snooze_rise_p1 <= snooze_btn & ~snooze_p0;
      stop_rise_p1   <= stop_btn & ~stop_p0;
      state          <= state_n;
      sec_cnt        <= sec_n;
      phase          <= phase_n;
      snooze_count   <= count_n;
      missed         <= missed_n;
      buzzer         <= buzz_drive(state_n, sec_n, phase_n);
      ringing        <= (state_n == RINGING);
      snoozed        <= (state_n == SNOOZED);
      remaining_sec  <= remain(state_n, sec_n);
    end
  end

endmodule

// File: tb/tb_alarm_ring_controller.sv
// tb_alarm_ring_controller
//   Scoreboard bench: a cycle model pushes the expected output vector on
//   every clk edge, and the DUT outputs are popped and compared 1 ns later.
//   Directed checks against hand-derived constants cover the key scenarios.
module tb_alarm_ring_controller;

  localparam int SN  = 5;
  localparam int RT  = 6;
  localparam int MX  = 2;
  localparam logic [9:0] SN10 = 10'(SN);
  localparam logic [9:0] RT10 = 10'(RT);
  localparam logic [9:0] HALF = 10'(RT / 2);
  localparam logic [2:0] MX3  = 3'(MX);

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       enable = 1'b1;
  logic       tick_1hz = 1'b0;
  logic       match = 1'b0;
  logic       snooze_btn = 1'b0;
  logic       stop_btn = 1'b0;
  logic       buzzer, ringing, snoozed, missed;
  logic [2:0] snooze_count;
  logic [9:0] remaining_sec;

  logic [16:0] dut_vec;
  assign dut_vec = {buzzer, ringing, snoozed, snooze_count, remaining_sec, missed};

  alarm_ring_controller #(
    .SNOOZE_SEC(SN), .RING_TIMEOUT_SEC(RT), .MAX_SNOOZES(MX)
  ) dut (
    .clk(clk), .reset(reset), .enable(enable), .tick_1hz(tick_1hz),
    .match(match), .snooze_btn(snooze_btn), .stop_btn(stop_btn),
    .buzzer(buzzer), .ringing(ringing), .snoozed(snoozed),
    .snooze_count(snooze_count), .remaining_sec(remaining_sec), .missed(missed)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  logic [16:0] exp_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  // Reference model state (0 idle, 1 ringing, 2 snoozed)
  int         m_st = 0;
  logic [9:0] m_sec = '0;
  logic       m_ph = 1'b0;
  logic [2:0] m_cnt = '0;
  logic       m_missed = 1'b0;
  logic       m_mh = 1'b0, m_sh = 1'b0, m_th = 1'b0;
  logic       m_me = 1'b0, m_se = 1'b0, m_te = 1'b0;

  task automatic model_edge();
    logic me, se, te, bz;
    logic [9:0] rem;
    if (reset) begin
      m_st = 0; m_sec = '0; m_ph = 1'b0; m_cnt = '0; m_missed = 1'b0;
      m_mh = 1'b0; m_sh = 1'b0; m_th = 1'b0;
      m_me = 1'b0; m_se = 1'b0; m_te = 1'b0;
    end else begin
      me = m_me; se = m_se; te = m_te;
      m_me = match & ~m_mh;
      m_se = snooze_btn & ~m_sh;
      m_te = stop_btn & ~m_th;
      m_mh = match; m_sh = snooze_btn; m_th = stop_btn;
      if (!enable) m_st = 0;
      else if (m_st == 0) begin
        if (me) begin m_st = 1; m_sec = '0; m_ph = 1'b1; m_cnt = '0; m_missed = 1'b0; end
      end else if (m_st == 1) begin
        if (te) begin m_st = 0; m_missed = 1'b0; end
        else if (se && (m_cnt < MX3)) begin m_st = 2; m_sec = '0; m_cnt = m_cnt + 3'd1; end
        else if (tick_1hz) begin
          m_sec = m_sec + 10'd1;
          m_ph = ~m_ph;
          if (m_sec == RT10) begin m_st = 0; m_missed = 1'b1; end
        end
      end else begin
        if (te) m_st = 0;
        else if (tick_1hz) begin
          m_sec = m_sec + 10'd1;
          if (m_sec == SN10) begin m_st = 1; m_sec = '0; m_ph = 1'b1; end
        end
      end
    end
    bz = 1'b0;
    if (m_st == 1) begin
`ifdef ALARM_ESCALATE_EN
      bz = (m_sec >= HALF) ? 1'b1 : m_ph;
`else
      bz = m_ph;
`endif
    end
    rem = (m_st == 2) ? (SN10 - m_sec) : 10'd0;
    exp_q.push_back({bz, m_st == 1, m_st == 2, m_cnt, rem, m_missed});
  endtask

  task automatic step();
    logic [16:0] e;
    @(posedge clk);
    model_edge();
    #1;
    e = exp_q.pop_front();
    chk("sb", 32'(dut_vec), 32'(e));
  endtask

  task automatic tick_pulse();
    tick_1hz = 1'b1; step();
    tick_1hz = 1'b0; step();
  endtask

  task automatic snooze_pulse();
    snooze_btn = 1'b1; step();
    snooze_btn = 1'b0; step();
  endtask

  task automatic start_session();
    match = 1'b0; step();
    match = 1'b1; step();
    step();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout checks=%0d", n_checks);
    $fatal(1, "watchdog");
  end

  logic exp_bz[6];

  initial begin
    // Test 1: reset, session start, buzzer pattern
    reset = 1'b1; step(); step();
    chk("rst_vec", 32'(dut_vec), 32'h0);
    reset = 1'b0;
    start_session();
    chk("t1_ringing", 32'(ringing), 1);
    chk("t1_buzzer", 32'(buzzer), 1);
    chk("t1_count", 32'(snooze_count), 0);
    tick_pulse(); chk("t1_bz1", 32'(buzzer), 0);
    tick_pulse(); chk("t1_bz2", 32'(buzzer), 1);
    tick_pulse();
`ifdef ALARM_ESCALATE_EN
    chk("t1_bz3", 32'(buzzer), 1);
`else
    chk("t1_bz3", 32'(buzzer), 0);
`endif
    chk("t1_still_ring", 32'(ringing), 1);

    // Test 2: snooze and resume
    snooze_pulse();
    chk("t2_snoozed", 32'(snoozed), 1);
    chk("t2_count", 32'(snooze_count), 1);
    chk("t2_rem", 32'(remaining_sec), 5);
    for (int i = 0; i < 5; i++) tick_pulse();
    chk("t2_ring", 32'(ringing), 1);
    chk("t2_buzzer", 32'(buzzer), 1);
    chk("t2_rem0", 32'(remaining_sec), 0);

    // Test 3: snooze limit and timeout
    snooze_pulse();
    chk("t3_count2", 32'(snooze_count), 2);
    for (int i = 0; i < 5; i++) tick_pulse();
    snooze_pulse();
    chk("t3_ignored_ring", 32'(ringing), 1);
    chk("t3_ignored_snz", 32'(snoozed), 0);
    chk("t3_count_hold", 32'(snooze_count), 2);
    for (int i = 0; i < 5; i++) tick_pulse();
    chk("t3_pre_timeout", 32'(ringing), 1);
    tick_pulse();
    chk("t3_timeout_ring", 32'(ringing), 0);
    chk("t3_missed", 32'(missed), 1);
    chk("t3_buzzer", 32'(buzzer), 0);

    // Test 4: simultaneous stop+snooze (with a coinciding tick), match while snoozed
    start_session();
    chk("t4_missed_clr", 32'(missed), 0);
    snooze_btn = 1'b1; stop_btn = 1'b1; step();
    snooze_btn = 1'b0; stop_btn = 1'b0; tick_1hz = 1'b1; step();
    tick_1hz = 1'b0;
    chk("t4_idle", 32'({ringing, snoozed}), 0);
    chk("t4_count", 32'(snooze_count), 0);
    chk("t4_missed", 32'(missed), 0);
    start_session();
    snooze_pulse();
    match = 1'b0; step();
    match = 1'b1; step(); step();
    chk("t4_match_snz", 32'(snoozed), 1);
    chk("t4_match_rem", 32'(remaining_sec), 5);
    chk("t4_match_cnt", 32'(snooze_count), 1);

    // Test 5: enable drop while snoozed, reset mid-ringing
    tick_pulse(); tick_pulse();
    chk("t5_rem3", 32'(remaining_sec), 3);
    enable = 1'b0; step();
    chk("t5_en_snz", 32'(snoozed), 0);
    chk("t5_en_rem", 32'(remaining_sec), 0);
    chk("t5_en_bz", 32'(buzzer), 0);
    enable = 1'b1; step();
    start_session();
    tick_pulse();
    match = 1'b0;
    reset = 1'b1; step();
    chk("t5_reset_vec", 32'(dut_vec), 32'h0);
    reset = 1'b0; step();

    // Test 6: buzzer per tick through to timeout
`ifdef ALARM_ESCALATE_EN
    exp_bz = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
`else
    exp_bz = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
`endif
    start_session();
    for (int i = 0; i < 6; i++) begin
      tick_pulse();
      chk($sformatf("t6_bz%0d", i + 1), 32'(buzzer), 32'(exp_bz[i]));
    end
    chk("t6_missed", 32'(missed), 1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/alarm_ring_controller.md
Name: alarm_ring_controller

Overview:
Sequences the alarm ringing session after the alarm time-match output asserts. It drives the buzzer with a 1 Hz on/off pattern and handles snooze (with a limited repeat count), stop, and the ring timeout. It sits between the alarm compare block (match source), the 1 Hz tick generator, the debounced user buttons, and the buzzer/LED outputs.

Parameters:
SNOOZE_SEC, 300, seconds spent in SNOOZED before ringing resumes (1..1023)
RING_TIMEOUT_SEC, 60, seconds of continuous RINGING before auto-stop (2..1023)
MAX_SNOOZES, 3, maximum snoozes per session (0..7)

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
enable  in  1  alarm armed; low forces IDLE
tick_1hz  in  1  one-clk pulse per second
match  in  1  level from the alarm compare block; its rising edge starts a session
snooze_btn  in  1  debounced level; its rising edge requests a snooze
stop_btn  in  1  debounced level; its rising edge ends the session
buzzer  out  1  buzzer drive
ringing  out  1  high in RINGING
snoozed  out  1  high in SNOOZED
snooze_count  out  3  snoozes used in the current session
remaining_sec  out  10  seconds left in SNOOZED; 0 otherwise
missed  out  1  sticky flag: last session ended by timeout

Behaviour:
- All state and outputs are registered. Reset is synchronous and active-high and applies on the clk edge.
- Reset values: state=IDLE; buzzer, ringing, snoozed, missed = 0; snooze_count = 0; remaining_sec = 0; sec_cnt = 0; phase = 0; edge-detect history regs = 0.
- Rising edges are detected as the input is high now and was low on the previous clk. One edge produces one action. The history regs update every cycle.
- Internal counters: sec_cnt is 10 bits, phase is 1 bit.
- Event priority within one cycle: reset > enable low > stop edge > snooze edge > tick.
- enable low: in any state, go to IDLE on the next clk; buzzer=0; missed is unchanged.
- IDLE:
  - On match edge with enable=1: go to RINGING, sec_cnt=0, phase=1, snooze_count=0, missed=0.
  - All other inputs are ignored.
- RINGING: buzzer=phase.
  - stop edge: go to IDLE, missed=0.
  - snooze edge with snooze_count<MAX_SNOOZES: go to SNOOZED, sec_cnt=0, snooze_count+1.
  - snooze edge with snooze_count==MAX_SNOOZES: ignored; ringing continues.
  - tick: sec_cnt+1 and phase toggles. If the new sec_cnt equals RING_TIMEOUT_SEC: go to IDLE, missed=1, buzzer=0 on that same edge.
- SNOOZED: buzzer=0; remaining_sec = SNOOZE_SEC - sec_cnt.
  - stop edge: go to IDLE.
  - snooze edge: ignored.
  - tick: sec_cnt+1. When the new sec_cnt equals SNOOZE_SEC: go to RINGING, sec_cnt=0, phase=1 (buzzer on in the first cycle of RINGING).
- A match edge while in RINGING or SNOOZED is ignored; there is no restart.
- Latency: a match, stop or snooze edge sampled at clk edge N is reflected on the outputs after clk edge N+1 (edge detect + state register).
- A tick that coincides with a state-changing stop or snooze edge is consumed, not counted.
- ringing = (state==RINGING) and snoozed = (state==SNOOZED), both registered alongside state.
- missed clears on a stop edge or on a new session start. Reset also clears it.

Optional Feature:
ALARM_ESCALATE_EN:
- Defined: in RINGING, once sec_cnt >= RING_TIMEOUT_SEC/2 (integer division), buzzer holds at 1 continuously instead of following phase. This also applies after a resume from SNOOZED, because sec_cnt restarts at 0.
- Undefined: buzzer always follows phase in RINGING.

Test Plan:
Bench parameters: SNOOZE_SEC=5, RING_TIMEOUT_SEC=6, MAX_SNOOZES=2.
1. Reset for 2 clk, then match rises with enable=1 -> two edges later ringing=1, buzzer=1, snooze_count=0. After 3 ticks -> buzzer pattern 0,1,0 and ringing still 1.
2. Ringing, snooze edge -> snoozed=1, snooze_count=1, remaining_sec=5. After 5 ticks -> ringing=1, buzzer=1, remaining_sec=0.
3. Snooze three times, waiting out each snooze -> the third snooze is ignored, ringing stays 1, snooze_count=2. Then 6 ticks -> state IDLE, missed=1, buzzer=0.
4. Ringing, stop and snooze edges in the same cycle -> IDLE, snooze_count unchanged, missed=0. A match edge while snoozed -> no change.
5. enable drops while in SNOOZED with remaining_sec=3 -> next clk IDLE, remaining_sec=0, buzzer=0. Synchronous reset mid-RINGING -> all outputs 0 after that clk.
6. With ALARM_ESCALATE_EN defined: ringing for 3 ticks -> buzzer held at 1 from tick 3 until the timeout at tick 6. Without the macro: buzzer toggles on every tick.
